// File: rtl/map_ctrl_pkg.sv
// Shared constants, opcodes and FSM encoding for the card-map update controller.
package map_ctrl_pkg;

    localparam int unsigned SLOTS    = 144;
    localparam int unsigned CARD_W   = 6;
    localparam int unsigned VB_START = 480;

    localparam logic [1:0] OP_WRITE     = 2'b00;
    localparam logic [1:0] OP_CLEAR     = 2'b01;
    localparam logic [1:0] OP_TOGGLE    = 2'b10;
    localparam logic [1:0] OP_DESEL_ALL = 2'b11;

    localparam logic [CARD_W-1:0] CARD_EMPTY = '0;

    // Requester identity, also the encoding of last_grant.
    localparam logic GNT_LOC = 1'b0;
    localparam logic GNT_REM = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StAck,
        StCommit
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; bit 0 = local, bit 1 = remote, last_grant 1 = remote.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/map_update_ctrl.sv
// Serialises local/remote edits into a shadow card map and publishes it at vblank start.
module map_update_ctrl
    import map_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [9:0]              v_cnt,
    input  logic                    loc_req,
    input  logic [1:0]              loc_op,
    input  logic [7:0]              loc_pos,
    input  logic [CARD_W-1:0]       loc_card,
    output logic                    loc_ack,
    input  logic                    rem_req,
    input  logic [1:0]              rem_op,
    input  logic [7:0]              rem_pos,
    input  logic [CARD_W-1:0]       rem_card,
    output logic                    rem_ack,
    output logic                    err,
    output logic                    busy,
    output logic [SLOTS*CARD_W-1:0] map,
    output logic [SLOTS-1:0]        sel_card
);

    state_e                    state;
    logic [SLOTS*CARD_W-1:0]   shadow_map;
    logic [SLOTS-1:0]          shadow_sel;
    logic [1:0]                op_q;
    logic [7:0]                pos_q;
    logic [CARD_W-1:0]         card_q;
    logic                      gnt_rem_q;
    logic                      last_grant;
    logic                      dirty;
    logic                      commit_pend;
    logic                      vb_q;

    logic                      vb;
    logic                      vb_rise;
    logic                      accept;
    logic [1:0]                grant;

    assign vb      = (v_cnt >= 10'(VB_START));
    assign vb_rise = vb & ~vb_q;
    assign accept  = (pos_q < 8'(SLOTS)) || (op_q == OP_DESEL_ALL);

    rr_arbiter2 u_arb (
        .req        ({rem_req, loc_req}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            shadow_map  <= '0;
            shadow_sel  <= '0;
            map         <= '0;
            sel_card    <= '0;
            op_q        <= OP_WRITE;
            pos_q       <= '0;
            card_q      <= CARD_EMPTY;
            gnt_rem_q   <= GNT_LOC;
            last_grant  <= GNT_REM;
            dirty       <= 1'b0;
            commit_pend <= 1'b0;
            vb_q        <= 1'b0;
            loc_ack     <= 1'b0;
            rem_ack     <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            vb_q <= vb;
            // An accepted edit finishing this edge counts as dirty for the frame.
            if (vb_rise && (dirty || (state == StExec && accept))) begin
                commit_pend <= 1'b1;
            end

            case (state)
                StIdle: begin
                    if (commit_pend || (vb_rise && dirty)) begin
                        state <= StCommit;
                        busy  <= 1'b1;
                    end else if (|grant) begin
                        state      <= StExec;
                        busy       <= 1'b1;
                        gnt_rem_q  <= grant[1];
                        last_grant <= grant[1];
                        op_q       <= grant[1] ? rem_op   : loc_op;
                        pos_q      <= grant[1] ? rem_pos  : loc_pos;
                        card_q     <= grant[1] ? rem_card : loc_card;
                    end
                end
                StExec: begin
                    state   <= StAck;
                    err     <= ~accept;
                    loc_ack <= ~gnt_rem_q;
                    rem_ack <= gnt_rem_q;
                    if (accept) begin
                        dirty <= 1'b1;
                        unique case (op_q)
                            OP_WRITE: shadow_map[int'(pos_q)*CARD_W +: CARD_W] <= card_q;
                            OP_CLEAR: begin
                                shadow_map[int'(pos_q)*CARD_W +: CARD_W] <= CARD_EMPTY;
                                shadow_sel[pos_q] <= 1'b0;
                            end
                            OP_TOGGLE:    shadow_sel[pos_q] <= ~shadow_sel[pos_q];
                            OP_DESEL_ALL: shadow_sel <= '0;
                        endcase
                    end
                end
                StAck: begin
                    state   <= StIdle;
                    busy    <= 1'b0;
                    loc_ack <= 1'b0;
                    rem_ack <= 1'b0;
                    err     <= 1'b0;
                end
                StCommit: begin
                    state       <= StIdle;
                    busy        <= 1'b0;
                    map         <= shadow_map;
                    sel_card    <= shadow_sel;
                    dirty       <= 1'b0;
                    commit_pend <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_map_update_ctrl.sv
// Directed bench for map_update_ctrl: edit vector table plus arbitration, vblank and reset cases.
module tb_map_update_ctrl;
    import map_ctrl_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [9:0]              v_cnt;
    logic                    loc_req, rem_req;
    logic [1:0]              loc_op, rem_op;
    logic [7:0]              loc_pos, rem_pos;
    logic [CARD_W-1:0]       loc_card, rem_card;
    logic                    loc_ack, rem_ack, err, busy;
    logic [SLOTS*CARD_W-1:0] map;
    logic [SLOTS-1:0]        sel_card;

    int tests = 0;
    int fails = 0;

    map_update_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .v_cnt    (v_cnt),
        .loc_req  (loc_req),
        .loc_op   (loc_op),
        .loc_pos  (loc_pos),
        .loc_card (loc_card),
        .loc_ack  (loc_ack),
        .rem_req  (rem_req),
        .rem_op   (rem_op),
        .rem_pos  (rem_pos),
        .rem_card (rem_card),
        .rem_ack  (rem_ack),
        .err      (err),
        .busy     (busy),
        .map      (map),
        .sel_card (sel_card)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rq;
        logic [1:0] op;
        logic [7:0] pos;
        logic [5:0] card;
        logic       exp_err;
        int         chk_pos;
        logic [5:0] pre_card;
        logic [5:0] post_card;
        logic       post_sel;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] slot(input int p);
        return map[p*CARD_W +: CARD_W];
    endfunction

    // One full request/ack handshake; ack must appear exactly two edges after req.
    task automatic do_edit(input logic rq, input logic [1:0] op, input logic [7:0] pos,
                           input logic [5:0] card, input logic exp_err);
        @(negedge clk);
        if (rq) begin
            rem_op = op; rem_pos = pos; rem_card = card; rem_req = 1'b1;
        end else begin
            loc_op = op; loc_pos = pos; loc_card = card; loc_req = 1'b1;
        end
        @(negedge clk);
        chk("ack_early", 32'({loc_ack, rem_ack}), 32'd0);
        chk("busy_exec", 32'(busy), 32'd1);
        @(negedge clk);
        chk("ack_own", 32'(rq ? rem_ack : loc_ack), 32'd1);
        chk("ack_other", 32'(rq ? loc_ack : rem_ack), 32'd0);
        chk("err", 32'(err), 32'(exp_err));
        loc_req = 1'b0;
        rem_req = 1'b0;
        @(negedge clk);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("ack_drop", 32'({loc_ack, rem_ack, err}), 32'd0);
    endtask

    task automatic vblank(input logic exp_commit, input int p, input logic [5:0] pre,
                          input logic [5:0] post, input logic post_sel);
        @(negedge clk);
        v_cnt = 10'd480;
        @(negedge clk);
        chk("vb_busy", 32'(busy), 32'(exp_commit));
        chk("vb_pre", 32'(slot(p)), 32'(pre));
        @(negedge clk);
        chk("vb_post_card", 32'(slot(p)), 32'(post));
        chk("vb_post_sel", 32'(sel_card[p]), 32'(post_sel));
        v_cnt = 10'd100;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w_cnt;
        logic got;

        //         rq    op             pos   card    err  chk  pre    post   sel
        vecs[0]  = '{1'b0, OP_WRITE,     8'd5,   6'h12, 1'b0, 5,   6'h00, 6'h12, 1'b0};
        vecs[1]  = '{1'b0, OP_TOGGLE,    8'd5,   6'h00, 1'b0, 5,   6'h12, 6'h12, 1'b1};
        vecs[2]  = '{1'b1, OP_WRITE,     8'd143, 6'h3f, 1'b0, 143, 6'h00, 6'h3f, 1'b0};
        vecs[3]  = '{1'b1, OP_TOGGLE,    8'd143, 6'h00, 1'b0, 143, 6'h3f, 6'h3f, 1'b1};
        vecs[4]  = '{1'b0, OP_TOGGLE,    8'd143, 6'h00, 1'b0, 143, 6'h3f, 6'h3f, 1'b0};
        vecs[5]  = '{1'b0, OP_CLEAR,     8'd5,   6'h2a, 1'b0, 5,   6'h12, 6'h00, 1'b0};
        vecs[6]  = '{1'b1, OP_WRITE,     8'd150, 6'h07, 1'b1, 143, 6'h3f, 6'h3f, 1'b0};
        vecs[7]  = '{1'b1, OP_TOGGLE,    8'd143, 6'h00, 1'b0, 143, 6'h3f, 6'h3f, 1'b1};
        vecs[8]  = '{1'b0, OP_DESEL_ALL, 8'd200, 6'h09, 1'b0, 143, 6'h3f, 6'h3f, 1'b0};
        vecs[9]  = '{1'b1, OP_CLEAR,     8'd143, 6'h00, 1'b0, 143, 6'h3f, 6'h00, 1'b0};
        vecs[10] = '{1'b0, OP_WRITE,     8'd0,   6'h01, 1'b0, 0,   6'h00, 6'h01, 1'b0};
        vecs[11] = '{1'b0, OP_WRITE,     8'd144, 6'h05, 1'b1, 0,   6'h01, 6'h01, 1'b0};
        vecs[12] = '{1'b1, OP_TOGGLE,    8'd255, 6'h00, 1'b1, 0,   6'h01, 6'h01, 1'b0};

        rst = 1'b1;
        v_cnt = 10'd100;
        loc_req = 1'b0; loc_op = OP_WRITE; loc_pos = '0; loc_card = '0;
        rem_req = 1'b0; rem_op = OP_WRITE; rem_pos = '0; rem_card = '0;
        #22;
        chk("rst_map", 32'(|map), 32'd0);
        chk("rst_sel", 32'(|sel_card), 32'd0);
        chk("rst_flags", 32'({loc_ack, rem_ack, err, busy}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Both requesting from reset: local wins the first tie, then strict alternation.
        @(negedge clk);
        loc_op = OP_WRITE; loc_pos = 8'd10; loc_card = 6'h01; loc_req = 1'b1;
        rem_op = OP_WRITE; rem_pos = 8'd11; rem_card = 6'h02; rem_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            w_cnt = 0;
            for (int w = 0; w < 8 && !got; w++) begin
                @(negedge clk);
                w_cnt++;
                if (loc_ack || rem_ack) got = 1'b1;
            end
            if (!got) begin
                tests++;
                fails++;
                $display("FAIL rr_timeout: no ack for grant %0d", k);
            end else begin
                chk("rr_order", 32'({loc_ack, rem_ack}), (k % 2 == 0) ? 32'd2 : 32'd1);
                if (k == 0) chk("rr_latency", 32'(w_cnt), 32'd2);
                else        chk("rr_spacing", 32'(w_cnt), 32'd3);
            end
            if (k == 3) begin
                loc_req = 1'b0;
                rem_req = 1'b0;
            end
        end
        @(negedge clk);
        vblank(1'b1, 10, 6'h00, 6'h01, 1'b0);
        chk("rr_slot11", 32'(slot(11)), 32'h02);

        for (int i = 0; i < 13; i++) begin
            do_edit(vecs[i].rq, vecs[i].op, vecs[i].pos, vecs[i].card, vecs[i].exp_err);
            vblank(~vecs[i].exp_err, vecs[i].chk_pos, vecs[i].pre_card,
                   vecs[i].post_card, vecs[i].post_sel);
        end

        // Vblank edge lands in the EXEC cycle: commit follows ACK and carries the edit.
        @(negedge clk);
        loc_op = OP_WRITE; loc_pos = 8'd0; loc_card = 6'h03; loc_req = 1'b1;
        @(negedge clk);
        v_cnt = 10'd480;
        @(negedge clk);
        chk("vbexec_ack", 32'(loc_ack), 32'd1);
        loc_req = 1'b0;
        @(negedge clk);
        chk("vbexec_old", 32'(slot(0)), 32'h01);
        @(negedge clk);
        chk("vbexec_commit", 32'(busy), 32'd1);
        chk("vbexec_hold", 32'(slot(0)), 32'h01);
        @(negedge clk);
        chk("vbexec_new", 32'(slot(0)), 32'h03);
        v_cnt = 10'd100;
        @(negedge clk);

        // Reset while an edit is in EXEC.
        @(negedge clk);
        loc_op = OP_WRITE; loc_pos = 8'd1; loc_card = 6'h09; loc_req = 1'b1;
        @(negedge clk);
        chk("rst_exec_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_map", 32'(|map), 32'd0);
        chk("rst_mid_sel", 32'(|sel_card), 32'd0);
        chk("rst_mid_flags", 32'({loc_ack, rem_ack, err, busy}), 32'd0);
        loc_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_no_ack", 32'({loc_ack, rem_ack, busy}), 32'd0);
        end
        do_edit(1'b0, OP_WRITE, 8'd1, 6'h09, 1'b0);
        vblank(1'b1, 1, 6'h00, 6'h09, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
